// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Operand-fetch pipeline stage. Holds a 32 x 32-bit register
//               file ($0 hard-wired to zero) with combinational write-through
//               reads, selects the two ALU operands (register, shift amount or
//               extended immediate) and registers them together with the ALU
//               control into a single-entry valid/ready output buffer.
//
// Ports       : clk, reset             - clock, synchronous active-high reset
//               in_valid / in_ready    - upstream handshake for decoded fields
//               rs_addr, rt_addr       - source register indices
//               imm, shamt, ExtOp      - immediate, shift amount, extend mode
//               ALUSrc1, ALUSrc2       - operand source selects
//               ALUCtl_in, Sign_in     - ALU control, passed through
//               wb_en/wb_addr/wb_data  - register write-back port
//               flush                  - discard the held output entry
//               out_valid / out_ready  - downstream handshake
//               in1, in2, ALUCtl, Sign - registered ALU operands and control
//               rt_data                - registered rt value (store data)
//
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter logic [31:0] REG_INIT = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [15:0] imm,
    input  logic [4:0]  shamt,
    input  logic        ExtOp,
    input  logic        ALUSrc1,
    input  logic        ALUSrc2,
    input  logic [4:0]  ALUCtl_in,
    input  logic        Sign_in,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic [4:0]  ALUCtl,
    output logic        Sign,
    output logic [31:0] rt_data
);

    localparam logic [4:0] c_ZERO_REG = 5'd0;

    logic [31:0] r_regs [0:31];

    logic        r_out_valid;
    logic [31:0] r_in1;
    logic [31:0] r_in2;
    logic [4:0]  r_alu_ctl;
    logic        r_sign;
    logic [31:0] r_rt_data;

    logic        w_wb_fire;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic [31:0] w_ext_imm;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic        w_in_ready;
    logic        w_accept;

    // A write to $0 is never performed; it must not bypass either.
    assign w_wb_fire = wb_en && (wb_addr != c_ZERO_REG);

    // Read ports: $0 reads zero, a same-cycle write to the index is forwarded.
    always_comb begin
        w_rs_data = r_regs[rs_addr];
        if (rs_addr == c_ZERO_REG) begin
            w_rs_data = 32'h0;
        end else if (w_wb_fire && (wb_addr == rs_addr)) begin
            w_rs_data = wb_data;
        end
    end

    always_comb begin
        w_rt_data = r_regs[rt_addr];
        if (rt_addr == c_ZERO_REG) begin
            w_rt_data = 32'h0;
        end else if (w_wb_fire && (wb_addr == rt_addr)) begin
            w_rt_data = wb_data;
        end
    end

    assign w_ext_imm = ExtOp ? {{16{imm[15]}}, imm} : {16'h0, imm};
    assign w_op1     = ALUSrc1 ? {27'h0, shamt} : w_rs_data;
    assign w_op2     = ALUSrc2 ? w_ext_imm : w_rt_data;

    // Buffer is free when empty or being drained this cycle; flush only
    // suppresses the accept so in_ready stays independent of it.
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready && !flush;

    // Register file. Reset has priority over a concurrent write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= REG_INIT;
            end
        end else if (w_wb_fire) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Output entry: reset > flush > accept > consume > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_in1       <= 32'h0;
            r_in2       <= 32'h0;
            r_alu_ctl   <= 5'h0;
            r_sign      <= 1'b0;
            r_rt_data   <= 32'h0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_in1       <= w_op1;
            r_in2       <= w_op2;
            r_alu_ctl   <= ALUCtl_in;
            r_sign      <= Sign_in;
            r_rt_data   <= w_rt_data;
        end else if (out_ready) begin
            // Data keeps its last value after the entry is consumed.
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign in1       = r_in1;
    assign in2       = r_in2;
    assign ALUCtl    = r_alu_ctl;
    assign Sign      = r_sign;
    assign rt_data   = r_rt_data;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Directed self-checking bench for operand_fetch. Inputs change
//               1 time unit after a rising edge; registered outputs are
//               compared at that same point, combinational in_ready after a
//               further settle delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    localparam logic [31:0] c_INIT = 32'h1111_2222;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic        ExtOp;
    logic        ALUSrc1;
    logic        ALUSrc2;
    logic [4:0]  ALUCtl_in;
    logic        Sign_in;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  ALUCtl;
    logic        Sign;
    logic [31:0] rt_data;

    int n_checks;
    int n_fail;

    operand_fetch #(.REG_INIT(c_INIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .imm       (imm),
        .shamt     (shamt),
        .ExtOp     (ExtOp),
        .ALUSrc1   (ALUSrc1),
        .ALUSrc2   (ALUSrc2),
        .ALUCtl_in (ALUCtl_in),
        .Sign_in   (Sign_in),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in1       (in1),
        .in2       (in2),
        .ALUCtl    (ALUCtl),
        .Sign      (Sign),
        .rt_data   (rt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset     = 1'b0;
        in_valid  = 1'b0;
        rs_addr   = 5'd0;
        rt_addr   = 5'd0;
        imm       = 16'h0;
        shamt     = 5'd0;
        ExtOp     = 1'b0;
        ALUSrc1   = 1'b0;
        ALUSrc2   = 1'b0;
        ALUCtl_in = 5'd0;
        Sign_in   = 1'b0;
        wb_en     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic s1,
                         input logic s2, input logic [4:0] ctl, input logic sg);
        in_valid  = 1'b1;
        rs_addr   = rs;
        rt_addr   = rt;
        ALUSrc1   = s1;
        ALUSrc2   = s2;
        ALUCtl_in = ctl;
        Sign_in   = sg;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();

        // Reset with concurrent write-back and accept: both overridden.
        reset = 1'b1;
        wb(5'd3, 32'h3333_3333);
        issue(5'd3, 5'd3, 1'b0, 1'b0, 5'h1F, 1'b1);
        step();
        step();
        idle();
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_in1", in1, 32'h0);
        check("rst_in2", in2, 32'h0);
        check("rst_ctl_sign", {26'h0, ALUCtl, Sign}, 32'h0);
        check("rst_rt_data", rt_data, 32'h0);
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Write-then-read.
        step();
        wb(5'd5, 32'h0000_1234);
        step();
        idle();
        issue(5'd5, 5'd0, 1'b0, 1'b0, 5'h0A, 1'b1);
        step();
        check("wtr_out_valid", {31'h0, out_valid}, 32'h1);
        check("wtr_in1", in1, 32'h0000_1234);
        check("wtr_in2", in2, 32'h0);
        check("wtr_ctl_sign", {26'h0, ALUCtl, Sign}, {26'h0, 5'h0A, 1'b1});

        // Same-cycle bypass; $3 holds REG_INIT since the reset-time write was lost.
        wb(5'd7, 32'hDEAD_BEEF);
        issue(5'd7, 5'd3, 1'b0, 1'b0, 5'h02, 1'b0);
        step();
        check("byp_in1", in1, 32'hDEAD_BEEF);
        check("byp_in2", in2, c_INIT);
        check("byp_rt_data", rt_data, c_INIT);
        check("byp_out_valid", {31'h0, out_valid}, 32'h1);

        // Write to $0 is neither stored nor forwarded.
        wb(5'd0, 32'hFFFF_FFFF);
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'h02, 1'b0);
        step();
        wb_en = 1'b0;
        check("r0_byp_in1", in1, 32'h0);
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'h02, 1'b0);
        step();
        check("r0_read_in1", in1, 32'h0);

        // Immediate sign extension, rt_data independent of ALUSrc2.
        issue(5'd7, 5'd5, 1'b0, 1'b1, 5'h04, 1'b1);
        imm   = 16'h8001;
        ExtOp = 1'b1;
        step();
        check("sext_in2", in2, 32'hFFFF_8001);
        check("sext_in1", in1, 32'hDEAD_BEEF);
        check("sext_rt_data", rt_data, 32'h0000_1234);

        // Zero extension and shift amount source.
        ExtOp   = 1'b0;
        ALUSrc1 = 1'b1;
        shamt   = 5'd31;
        step();
        check("zext_in2", in2, 32'h0000_8001);
        check("shamt_in1", in1, 32'h0000_001F);

        // Consume without accept: valid drops, data retained.
        idle();
        step();
        check("drain_out_valid", {31'h0, out_valid}, 32'h0);
        check("drain_in1_kept", in1, 32'h0000_001F);

        // Backpressure: accept A then stall three cycles while rewriting sources.
        issue(5'd5, 5'd7, 1'b0, 1'b0, 5'h03, 1'b0);
        out_ready = 1'b0;
        step();
        check("bp_a_valid", {31'h0, out_valid}, 32'h1);
        check("bp_a_in1", in1, 32'h0000_1234);
        check("bp_a_in2", in2, 32'hDEAD_BEEF);
        issue(5'd7, 5'd5, 1'b1, 1'b1, 5'h1F, 1'b1);
        shamt = 5'd9;
        imm   = 16'h0042;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) wb(5'd5, 32'hCAFE_0000);
            else if (c == 1) wb(5'd7, 32'h0BAD_F00D);
            else wb_en = 1'b0;
            #1;
            check("bp_in_ready", {31'h0, in_ready}, 32'h0);
            step();
            check("bp_hold_valid", {31'h0, out_valid}, 32'h1);
            check("bp_hold_in1", in1, 32'h0000_1234);
            check("bp_hold_in2", in2, 32'hDEAD_BEEF);
            check("bp_hold_ctl", {27'h0, ALUCtl}, 32'h3);
        end
        // Release with B valid: replaced back-to-back.
        issue(5'd5, 5'd7, 1'b0, 1'b0, 5'h1F, 1'b1);
        out_ready = 1'b1;
        #1;
        check("bp_rel_in_ready", {31'h0, in_ready}, 32'h1);
        step();
        check("bp_b_valid", {31'h0, out_valid}, 32'h1);
        check("bp_b_in1", in1, 32'hCAFE_0000);
        check("bp_b_in2", in2, 32'h0BAD_F00D);
        check("bp_b_ctl_sign", {26'h0, ALUCtl, Sign}, {26'h0, 5'h1F, 1'b1});

        // Hold B, then flush with a would-be accept and a concurrent write-back.
        idle();
        out_ready = 1'b0;
        step();
        check("fl_pre_valid", {31'h0, out_valid}, 32'h1);
        issue(5'd0, 5'd0, 1'b1, 1'b0, 5'h06, 1'b0);
        shamt     = 5'd3;
        out_ready = 1'b1;
        flush     = 1'b1;
        wb(5'd9, 32'h0000_0099);
        step();
        idle();
        check("fl_valid", {31'h0, out_valid}, 32'h0);
        check("fl_in1_kept", in1, 32'hCAFE_0000);
        check("fl_ctl_kept", {27'h0, ALUCtl}, 32'h1F);
        issue(5'd9, 5'd0, 1'b0, 1'b0, 5'h01, 1'b0);
        step();
        check("fl_wb_done", in1, 32'h0000_0099);

        // Reset during a stall discards the entry and restores REG_INIT.
        issue(5'd5, 5'd9, 1'b0, 1'b0, 5'h0C, 1'b1);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("rs_stall_valid", {31'h0, out_valid}, 32'h1);
        reset = 1'b1;
        step();
        idle();
        check("rs_valid", {31'h0, out_valid}, 32'h0);
        check("rs_in1", in1, 32'h0);
        check("rs_in2", in2, 32'h0);
        check("rs_ctl_sign", {26'h0, ALUCtl, Sign}, 32'h0);
        step();
        check("rs_no_emit", {31'h0, out_valid}, 32'h0);
        issue(5'd5, 5'd9, 1'b0, 1'b0, 5'h00, 1'b0);
        step();
        idle();
        check("rs_reg5", in1, c_INIT);
        check("rs_reg9", in2, c_INIT);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
